transmitter: RTL and testbench
==============================

// Module: transmitter
// PURPOSE
//  UART transmit stage; peer of the receive stage on the same serial link.
//  Takes a byte from the transmit buffer register (TBR) when the buffer-full
//  handshake allows it, and serialises one frame on TxD, LSB first:
//  start(0), 8 data, parity, stop(1).
//  The byte is held in a transmit shift register (TSR), so the CPU can refill
//  TBR while a frame is on the line. Status flags are updated by an external
//  control/status register via one-cycle pulse outputs.
// PARAMETERS
//  DATA_BITS  8  data bits per frame; the frame carries DATA_BITS+1 payload bits including parity
// PORTS
//  clk      in   1          system clock
//  rst      in   1          reset, asynchronous, active-high
//  TxEn     in   1          bit-rate tick, 1 clk wide; one pulse per bit period (RxEn/8)
//  TBR      in   DATA_BITS  transmit buffer register contents
//  TBRE     in   1          TBR empty flag; 0 = byte waiting
//  PRT      in   1          parity type: 0 = even, 1 = odd
//  TxD      out  1          serial output, registered, idles high
//  clrTBRE  out  1          1-clk pulse: TBR copied into TSR; status register sets TBRE
//  TSRE     out  1          TSR empty: 1 when the FSM is in IDLE
// BEHAVIOUR
//  Reset: TxD=1, clrTBRE=0, TSRE=1, state=IDLE, TSR=0, BitCnt=0.
//   Async: a mid-frame reset forces TxD high at once and abandons the frame.
//  State changes, TxD updates and shifts happen only on clk edges where TxEn=1.
//   TxEn=0 holds all state.
//  Parity bit: PB = ^TBR ^ PRT. The XOR of the 9 payload bits therefore equals PRT.
//  IDLE: TxD=1.
//   If TxEn & !TBRE: TSR<={PB,TBR}, TxD<=0 (start bit), BitCnt<=0,
//   clrTBRE=1 for that cycle only (combinational, decoded from state/TxEn/TBRE),
//   then go to SEND.
//  SEND:
//   On TxEn with BitCnt<DATA_BITS+1: TxD<=TSR[0], TSR<=TSR>>1, BitCnt++.
//   On TxEn with BitCnt==DATA_BITS+1: TxD<=1 (stop bit), BitCnt<=0, go to STOP.
//  STOP: on TxEn:
//   If !TBRE: back-to-back frame. Same actions as the IDLE load (start bit,
//   clrTBRE pulse), then go to SEND. No extra idle bit.
//   Else go to IDLE.
//  Each line bit lasts exactly one TxEn period. A frame is 11 TxEn periods from
//  start-bit edge to the end of the stop bit.
//  TBR is sampled only on the load edge. Later TBR changes do not affect the
//  frame in flight.
//  TBRE falling mid-frame has no effect until STOP or IDLE.
//  TxEn held continuously high is legal; each clk is then one bit.
//  Illegal state encodings go to IDLE with TxD=1.
//  clrTBRE never asserts when TxEn=0 or TBRE=1.
// STRUCTURE
//  Shared header uart_defs.vh, also used by the receive stage:
//   - state encodings IDLE/SEND/STOP
//   - frame constants: DATA_BITS, FRAME_PAYLOAD = DATA_BITS+1
//   - parity function par(data, prt)
//  No sub-module. Consists of the FSM, a 4-bit BitCnt, a 9-bit TSR and the TxD register.
// TESTING
//  1. TBR=8'hA5, PRT=0, TBRE=0 for 1 clk, TxEn every 16 clk.
//     -> clrTBRE pulses once.
//     -> TxD per bit period: 0,1,0,1,0,0,1,0,1, parity 0, stop 1, then idle 1.
//     -> TSRE=0 throughout the frame.
//  2. Same with PRT=1 -> parity bit 1. TBR=8'h07, PRT=0 -> parity bit 1.
//  3. Back-to-back: 8'h55 then 8'h0F, second byte loaded while the first is in SEND.
//     -> second start bit directly follows the first stop bit.
//     -> exactly 2 clrTBRE pulses; TSRE stays 0 between the frames.
//  4. TxEn gaps: TxEn=0 for 40 clks mid-frame -> TxD and BitCnt are frozen; the frame resumes intact.
//  5. Reset asserted at data bit 4 -> TxD=1 and TSRE=1 immediately.
//     A new byte afterwards is sent cleanly.
//  6. Loopback into the receive stage (RxEn 8x TxEn, random bytes, both PRT values):
//     -> RBR equals the sent byte; setPE=setFE=setOE=0.

Source files
------------

// File: rtl/transmitter_pkg.sv
// Shared UART definitions: transmitter FSM states, frame sizing and the parity rule.
package transmitter_pkg;

    // Default number of data bits per frame.
    localparam int DEF_DATA_BITS = 8;

    // Widest data field the parity helper accepts; narrower bytes are zero-extended.
    localparam int MAX_DATA_BITS = 16;

    // Transmit FSM states. The fourth 2-bit code is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SEND = 2'b01,
        STOP = 2'b10
    } state_t;

    // Parity bit for a data word: the XOR of the data bits and the parity bit equals prt
    // (prt=0 gives even parity, prt=1 gives odd parity). Zero-extension leaves the XOR unchanged.
    function automatic logic par(input logic [MAX_DATA_BITS-1:0] data, input logic prt);
        return (^data) ^ prt;
    endfunction

endpackage

// File: rtl/transmitter.sv
// UART transmit stage. On a bit-rate tick it loads the waiting TBR byte and its parity
// bit into the shift register. It then sends start, data (LSB first), parity and stop
// bits on TxD, with one bit per TxEn period.
module transmitter
    import transmitter_pkg::*;
#(
    parameter int DATA_BITS = DEF_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 TxEn,
    input  logic [DATA_BITS-1:0] TBR,
    input  logic                 TBRE,
    input  logic                 PRT,
    output logic                 TxD,
    output logic                 clrTBRE,
    output logic                 TSRE
);

    // Payload is data plus parity. The counter must reach PAYLOAD to mark the stop bit.
    localparam int                PAYLOAD  = DATA_BITS + 1;
    localparam int                CNT_W    = $clog2(PAYLOAD + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(PAYLOAD);

    state_t             r_state;
    state_t             w_next_state;
    logic               r_txd;
    logic [PAYLOAD-1:0] r_tsr;
    logic [CNT_W-1:0]   r_bit_cnt;

    logic               w_load;
    logic               w_shift;
    logic               w_stop_bit;
    logic               w_illegal;
    logic               w_tsre;
    logic               w_parity;

    assign w_parity = par(MAX_DATA_BITS'(TBR), PRT);

    // State register; advances only on ticks because the next-state logic holds otherwise.
    // NOTE: every clocked assignment is non-blocking so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode: load from IDLE/STOP when a byte waits, stop after the parity bit.
    // NOTE: the default assignment at the top keeps this combinational block free of latches.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (TxEn && !TBRE) begin
                    w_next_state = SEND;
                end
            end
            SEND: begin
                if (TxEn && (r_bit_cnt >= LAST_CNT)) begin
                    w_next_state = STOP;
                end
            end
            STOP: begin
                if (TxEn) begin
                    w_next_state = TBRE ? IDLE : SEND;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Output and datapath-control decode from the current state and the tick.
    always_comb begin
        w_load     = 1'b0;
        w_shift    = 1'b0;
        w_stop_bit = 1'b0;
        w_illegal  = 1'b0;
        w_tsre     = 1'b0;
        case (r_state)
            IDLE: begin
                w_tsre = 1'b1;
                w_load = TxEn & ~TBRE;
            end
            SEND: begin
                if (TxEn) begin
                    if (r_bit_cnt < LAST_CNT) begin
                        w_shift = 1'b1;
                    end else begin
                        w_stop_bit = 1'b1;
                    end
                end
            end
            STOP: begin
                w_load = TxEn & ~TBRE;
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    assign clrTBRE = w_load;
    assign TSRE    = w_tsre;
    assign TxD     = r_txd;

    // Shift register, bit counter and registered line output. Reset drives the line idle at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_txd     <= 1'b1;
            r_tsr     <= '0;
            r_bit_cnt <= '0;
        end else if (w_illegal) begin
            r_txd     <= 1'b1;
            r_bit_cnt <= '0;
        end else if (w_load) begin
            r_tsr     <= {w_parity, TBR};
            r_txd     <= 1'b0;
            r_bit_cnt <= '0;
        end else if (w_shift) begin
            r_txd     <= r_tsr[0];
            r_tsr     <= r_tsr >> 1;
            r_bit_cnt <= r_bit_cnt + 1'b1;
        end else if (w_stop_bit) begin
            r_txd     <= 1'b1;
            r_bit_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_transmitter.sv
// Self-checking bench for the UART transmitter. It models the CPU and the status
// register around the transmitter. A line-level reference model predicts TxD, TSRE
// and clrTBRE on every clock.
module tb_transmitter;

    localparam int DB = 8;

    logic          clk  = 1'b0;
    logic          rst  = 1'b1;
    logic          TxEn = 1'b0;
    logic [DB-1:0] TBR  = '0;
    logic          TBRE = 1'b1;
    logic          PRT  = 1'b0;
    logic          TxD;
    logic          clrTBRE;
    logic          TSRE;

    transmitter #(.DATA_BITS(DB)) dut (
        .clk     (clk),
        .rst     (rst),
        .TxEn    (TxEn),
        .TBR     (TBR),
        .TBRE    (TBRE),
        .PRT     (PRT),
        .TxD     (TxD),
        .clrTBRE (clrTBRE),
        .TSRE    (TSRE)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;

    // Reference model. k is the position of the current line bit within the frame:
    // 0 is the start bit, 1..9 are the payload bits, 10 is the stop bit, and 11 means idle.
    int          k         = 11;
    logic [10:0] frame     = '1;
    logic        prev_en   = 1'b0;
    logic        prev_load = 1'b0;
    logic        prev_clr  = 1'b0;
    logic        exp_load;
    int          n_clr     = 0;
    int          n_pushed  = 0;
    logic        line_q[$];
    logic [8:0]  wr_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Complete line frame, LSB first: start 0, data, parity (ones count plus prt is even), stop 1.
    function automatic logic [10:0] make_frame(input logic [7:0] d, input logic prt);
        logic p;
        p = logic'(($countones(d) + int'(prt)) % 2);
        return {1'b1, p, d, 1'b0};
    endfunction

    // One clock: observe the previous edge at negedge, run the CPU/status register, drive TxEn.
    task automatic cycle(input logic en);
        @(negedge clk);
        if (prev_en) begin
            line_q.push_back(TxD);
            if (prev_load) k = 0;
            else if (k < 11) k++;
        end
        check("txd", TxD, (k >= 11) ? 1'b1 : frame[k]);
        check("tsre", TSRE, k >= 11);
        if (prev_clr) begin
            TBRE = 1'b1;
            TBR  = 8'($urandom);
        end
        if (TBRE && wr_q.size() > 0) begin
            {PRT, TBR} = wr_q.pop_front();
            TBRE = 1'b0;
        end
        TxEn = en;
        #1;
        exp_load = en && !TBRE && (k >= 10);
        check("clr", clrTBRE, exp_load);
        if (exp_load) frame = make_frame(TBR, PRT);
        prev_en   = en;
        prev_load = exp_load;
        prev_clr  = clrTBRE;
        if (clrTBRE) n_clr++;
    endtask

    task automatic run_ticks(input int nticks, input int period);
        for (int t = 0; t < nticks; t++) begin
            cycle(1'b1);
            for (int g = 1; g < period; g++) cycle(1'b0);
        end
    endtask

    task automatic push_byte(input logic prt, input logic [7:0] d);
        wr_q.push_back({prt, d});
        n_pushed++;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        TxEn = 1'b0;
        TBRE = 1'b1;
        TBR  = '0;
        PRT  = 1'b0;
        k = 11; frame = '1;
        prev_en = 1'b0; prev_load = 1'b0; prev_clr = 1'b0;
        n_clr = 0; n_pushed = 0;
        wr_q.delete();
        line_q.delete();
        repeat (2) @(negedge clk);
        check("rst_txd", TxD, 1);
        check("rst_tsre", TSRE, 1);
        check("rst_clr", clrTBRE, 0);
        rst = 1'b0;
    endtask

    function automatic logic line_at(input int i);
        return (i < line_q.size()) ? line_q[i] : 1'bx;
    endfunction

    initial begin
        logic exp_a5 [12];
        exp_a5 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        // Single A5 frame, even parity, slow tick.
        do_reset();
        push_byte(1'b0, 8'hA5);
        run_ticks(13, 16);
        for (int i = 0; i < 12; i++) check($sformatf("a5_bit%0d", i), line_at(i), exp_a5[i]);
        check("a5_clr_count", n_clr, 1);

        // Odd parity on A5, then an odd-weight byte with even parity.
        do_reset();
        push_byte(1'b1, 8'hA5);
        run_ticks(13, 4);
        check("a5_odd_parity", line_at(9), 1);
        do_reset();
        push_byte(1'b0, 8'h07);
        run_ticks(13, 3);
        check("07_even_parity", line_at(9), 1);

        // Back-to-back frames: second start bit immediately follows the first stop bit.
        do_reset();
        push_byte(1'b0, 8'h55);
        push_byte(1'b1, 8'h0F);
        run_ticks(24, 5);
        check("b2b_stop1", line_at(10), 1);
        check("b2b_start2", line_at(11), 0);
        check("b2b_stop2", line_at(21), 1);
        check("b2b_idle", line_at(22), 1);
        check("b2b_clr_count", n_clr, 2);

        // TxEn gap of 40 clocks mid-frame: line frozen, frame resumes intact.
        do_reset();
        push_byte(1'b1, 8'h96);
        run_ticks(5, 4);
        repeat (40) cycle(1'b0);
        run_ticks(10, 4);
        check("gap_clr_count", n_clr, 1);
        check("gap_tsre_end", TSRE, 1);

        // Asynchronous reset while data bit 4 (a 0 for C3) is on the line.
        do_reset();
        push_byte(1'b0, 8'hC3);
        run_ticks(6, 6);
        check("mid_pre_reset_txd", TxD, 0);
        rst = 1'b1;
        #1;
        check("mid_reset_txd", TxD, 1);
        check("mid_reset_tsre", TSRE, 1);
        do_reset();
        push_byte(1'b1, 8'h3C);
        run_ticks(13, 2);
        check("after_reset_clr", n_clr, 1);

        // Random bytes, parity types, tick periods (including continuous TxEn) and write timing.
        do_reset();
        for (int f = 0; f < 150; f++) begin
            if ($urandom_range(0, 1) == 1) push_byte(1'($urandom), 8'($urandom));
            if ($urandom_range(0, 7) == 0) push_byte(1'($urandom), 8'($urandom));
            run_ticks($urandom_range(1, 15), $urandom_range(1, 6));
            if ($urandom_range(0, 9) == 0) repeat ($urandom_range(1, 30)) cycle(1'b0);
        end
        for (int i = 0; i < 20000 && (wr_q.size() > 0 || !TBRE || TSRE !== 1'b1); i++) begin
            cycle(1'(i % 2));
        end
        run_ticks(2, 1);
        check("rand_drained", wr_q.size(), 0);
        check("rand_clr_count", n_clr, n_pushed);
        check("rand_tsre_end", TSRE, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
